// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch-side initiator of the RV32IM instruction-memory interface. Owns the
// program counter, issues word-address reads to a (possibly multi-cycle)
// busywait memory, buffers returned words with their PCs in a 2-entry queue
// and presents the head entry to IF/ID under a VALID_OUT / STALL handshake.
// Branch/jump redirects flush the queue. A redirect that lands on an
// outstanding read first drains that read, then fetches from the saved target.
//
// Ports:
//   CLK            clock; all state updates on the rising edge
//   RESET          synchronous, active-low reset
//   MEM_READ       read request to instruction memory
//   MEM_ADDRESS    word address, fetch_pc[ADDR_W+1:2]
//   MEM_READDATA   instruction word returned by memory
//   MEM_BUSYWAIT   memory busy; a read completes when MEM_READ && !MEM_BUSYWAIT
//   STALL          IF/ID not accepting; head entry is held
//   BRANCH_TAKEN   redirect request from EX
//   BRANCH_TARGET  redirect PC
//   INSTR_OUT      head instruction (NOP_INSTR when invalid)
//   PC_OUT         PC of head instruction (0 when invalid)
//   VALID_OUT      head entry valid
//   FAULT          sticky misaligned-redirect flag
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              MEM_READ,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  input  logic [31:0]       MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  input  logic              STALL,
  input  logic              BRANCH_TAKEN,
  input  logic [31:0]       BRANCH_TARGET,
  output logic [31:0]       INSTR_OUT,
  output logic [31:0]       PC_OUT,
  output logic              VALID_OUT,
  output logic              FAULT
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DRAIN   = 2'd2,
    S_FAULTED = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifq_entry_t;

  state_t            state, state_nxt;
  logic [31:0]       fetch_pc, fetch_pc_nxt;
  logic [31:0]       drain_tgt, drain_tgt_nxt;
  ifq_entry_t [1:0]  q, q_nxt;          // q[0] is the head
  logic [1:0]        count, count_nxt;

  logic       head_vld;
  logic       pop_req;
  logic       fetch_rd;
  logic       mem_rd;
  logic       done;
  logic       in_flight;
  logic       flush;
  logic       push;
  logic       pop;
  logic       misalign;
  ifq_entry_t new_ent;

  // --------------------------------------------------------------------------
  // Handshake / request decode
  // --------------------------------------------------------------------------
  assign head_vld  = (count != 2'd0);
  assign pop_req   = head_vld && !STALL;

  // A full queue may still fetch when the head leaves this cycle. pop_req
  // ignores BRANCH_TAKEN on purpose so MEM_READ never depends on the redirect
  // input; a completion in a redirect cycle is simply dropped.
  assign fetch_rd  = (count != 2'd2) || pop_req;

  // RESET gates the request so nothing is issued while reset is asserted.
  assign mem_rd    = RESET && (((state == S_FETCH) && fetch_rd) || (state == S_DRAIN));
  assign done      = mem_rd && !MEM_BUSYWAIT;
  assign in_flight = mem_rd && MEM_BUSYWAIT;
  assign misalign  = (BRANCH_TARGET[1:0] != 2'b00);

  // FAULTED already holds an empty queue; a redirect there is ignored.
  assign flush     = BRANCH_TAKEN && (state != S_FAULTED);
  assign push      = !flush && (state == S_FETCH) && done;
  assign pop       = !flush && ((state == S_FETCH) || (state == S_HOLD)) && pop_req;

  assign new_ent.instr = MEM_READDATA;
  assign new_ent.pc    = fetch_pc;

  // --------------------------------------------------------------------------
  // Two-entry shift queue
  // --------------------------------------------------------------------------
  always_comb begin
    q_nxt     = q;
    count_nxt = count;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) q_nxt[0] = new_ent;
          else               q_nxt[1] = new_ent;
          count_nxt = count + 2'd1;
        end
        2'b01: begin
          q_nxt[0]  = q[1];
          count_nxt = count - 2'd1;
        end
        2'b11: begin
          // count is 1 or 2 here (a pop needs a valid head)
          if (count == 2'd1) begin
            q_nxt[0] = new_ent;
          end else begin
            q_nxt[0] = q[1];
            q_nxt[1] = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / PC logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    drain_tgt_nxt = drain_tgt;

    if (flush) begin
      if (misalign) begin
        state_nxt = S_FAULTED;
      end else if (in_flight) begin
        // Memory must see the request through with a stable address; the
        // target waits in drain_tgt (a later redirect overwrites it).
        state_nxt     = S_DRAIN;
        drain_tgt_nxt = BRANCH_TARGET;
      end else begin
        state_nxt    = S_FETCH;
        fetch_pc_nxt = BRANCH_TARGET;
      end
    end else begin
      unique case (state)
        S_FETCH: begin
          if (done) fetch_pc_nxt = fetch_pc + 32'd4;
          if ((count_nxt == 2'd2) && !pop) state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (pop) state_nxt = S_FETCH;
        end
        S_DRAIN: begin
          // Returned word belongs to the abandoned stream; discard it.
          if (done) begin
            fetch_pc_nxt = drain_tgt;
            state_nxt    = S_FETCH;
          end
        end
        S_FAULTED: ;
        default: state_nxt = S_FAULTED;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= S_FETCH;
      fetch_pc  <= RESET_VECTOR;
      drain_tgt <= 32'd0;
      q         <= '0;
      count     <= 2'd0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      drain_tgt <= drain_tgt_nxt;
      q         <= q_nxt;
      count     <= count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign MEM_READ    = mem_rd;
  assign MEM_ADDRESS = fetch_pc[ADDR_W+1:2];
  assign VALID_OUT   = head_vld;
  assign INSTR_OUT   = head_vld ? q[0].instr : NOP_INSTR;
  assign PC_OUT      = head_vld ? q[0].pc    : 32'd0;
  assign FAULT       = (state == S_FAULTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. A small behavioural instruction memory
// returns a fixed word per address and asserts MEM_BUSYWAIT for wait_cycles
// cycles at the start of each read. Inputs change 1 time unit after the rising
// edge; outputs are sampled a further unit later, well away from the edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          ADDR_W = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              CLK;
  logic              RESET;
  logic              MEM_READ;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [31:0]       MEM_READDATA;
  logic              MEM_BUSYWAIT;
  logic              STALL;
  logic              BRANCH_TAKEN;
  logic [31:0]       BRANCH_TARGET;
  logic [31:0]       INSTR_OUT;
  logic [31:0]       PC_OUT;
  logic              VALID_OUT;
  logic              FAULT;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .ADDR_W       (ADDR_W),
    .NOP_INSTR    (NOP)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .MEM_READ      (MEM_READ),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .INSTR_OUT     (INSTR_OUT),
    .PC_OUT        (PC_OUT),
    .VALID_OUT     (VALID_OUT),
    .FAULT         (FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // --------------------------------------------------------------------------
  // Memory model: word 0/1 hold real instructions, other words 0xA000_aa13
  // --------------------------------------------------------------------------
  function automatic logic [31:0] memword(input logic [ADDR_W-1:0] a);
    if (a == 8'd0)      return 32'h0010_0093;
    else if (a == 8'd1) return 32'h0020_8113;
    else                return 32'hA000_0013 | ({24'd0, a} << 8);
  endfunction

  logic [3:0] wcnt = 4'd0;
  logic [3:0] wait_cycles = 4'd0;
  int         ncomp = 0;

  assign MEM_READDATA = memword(MEM_ADDRESS);
  assign MEM_BUSYWAIT = MEM_READ && (wcnt != wait_cycles);

  always @(posedge CLK) begin
    wcnt <= (MEM_READ && MEM_BUSYWAIT) ? wcnt + 4'd1 : 4'd0;
    if (RESET && MEM_READ && !MEM_BUSYWAIT) ncomp <= ncomp + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Leaves the bench sampling in the first cycle after reset release.
  task automatic do_reset(input logic stall, input logic [3:0] wc);
    RESET = 1'b0; STALL = stall; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'd0;
    wait_cycles = wc;
    tick(); tick();
    RESET = 1'b1;
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'd0;
    wait_cycles = 4'd0;
    tick(); tick();
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL rst_mem_read got=%b exp=0", MEM_READ); end
    checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", VALID_OUT); end
    checks++; if (INSTR_OUT !== NOP) begin errors++; $display("FAIL rst_instr got=%h exp=%h", INSTR_OUT, NOP); end
    checks++; if (PC_OUT !== 32'd0) begin errors++; $display("FAIL rst_pc got=%h exp=0", PC_OUT); end
    checks++; if (FAULT !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", FAULT); end
    RESET = 1'b1; #1;
    checks++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'd0) begin errors++; $display("FAIL rst_first_req got rd=%b addr=%h exp rd=1 addr=00", MEM_READ, MEM_ADDRESS); end
    checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL rst_first_valid got=%b exp=0", VALID_OUT); end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'h0 || INSTR_OUT !== 32'h0010_0093) begin errors++; $display("FAIL rst_out0 got v=%b pc=%h i=%h exp v=1 pc=0 i=00100093", VALID_OUT, PC_OUT, INSTR_OUT); end
    checks++; if (MEM_ADDRESS !== 8'd1) begin errors++; $display("FAIL rst_addr1 got=%h exp=01", MEM_ADDRESS); end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'h4 || INSTR_OUT !== 32'h0020_8113) begin errors++; $display("FAIL rst_out1 got v=%b pc=%h i=%h exp v=1 pc=4 i=00208113", VALID_OUT, PC_OUT, INSTR_OUT); end
    checks++; if (MEM_ADDRESS !== 8'd2) begin errors++; $display("FAIL rst_addr2 got=%h exp=02", MEM_ADDRESS); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stall();
    int c0;
    do_reset(1'b1, 4'd0);
    c0 = ncomp;
    repeat (5) tick();
    checks++; if (ncomp - c0 !== 2) begin errors++; $display("FAIL stall_completions got=%0d exp=2", ncomp - c0); end
    checks++; if (MEM_READ !== 1'b0) begin errors++; $display("FAIL stall_hold_rd got=%b exp=0", MEM_READ); end
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'h0) begin errors++; $display("FAIL stall_head got v=%b pc=%h exp v=1 pc=0", VALID_OUT, PC_OUT); end
    STALL = 1'b0; #1;
    checks++; if (PC_OUT !== 32'h0 || MEM_READ !== 1'b0) begin errors++; $display("FAIL stall_rel0 got pc=%h rd=%b exp pc=0 rd=0", PC_OUT, MEM_READ); end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'h4) begin errors++; $display("FAIL stall_rel4 got v=%b pc=%h exp v=1 pc=4", VALID_OUT, PC_OUT); end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'h8 || INSTR_OUT !== 32'hA000_0213) begin errors++; $display("FAIL stall_rel8 got v=%b pc=%h i=%h exp v=1 pc=8 i=a0000213", VALID_OUT, PC_OUT, INSTR_OUT); end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'hC || INSTR_OUT !== 32'hA000_0313) begin errors++; $display("FAIL stall_rel12 got v=%b pc=%h i=%h exp v=1 pc=c i=a0000313", VALID_OUT, PC_OUT, INSTR_OUT); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_busywait();
    do_reset(1'b0, 4'd3);
    for (int k = 1; k <= 13; k++) begin
      logic [7:0]  ea;
      logic        ev;
      logic [31:0] ep;
      if (k > 1) tick();
      ea = 8'((k - 1) / 4);
      ev = (k > 1) && (k % 4 == 1);
      ep = 32'(((k - 5) / 4) * 4);
      checks++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== ea) begin errors++; $display("FAIL bw_addr cyc=%0d got rd=%b addr=%h exp rd=1 addr=%h", k, MEM_READ, MEM_ADDRESS, ea); end
      checks++; if (VALID_OUT !== ev) begin errors++; $display("FAIL bw_valid cyc=%0d got=%b exp=%b", k, VALID_OUT, ev); end
      if (ev) begin
        checks++; if (PC_OUT !== ep) begin errors++; $display("FAIL bw_pc cyc=%0d got=%h exp=%h", k, PC_OUT, ep); end
      end
    end
    checks++; if (INSTR_OUT !== 32'hA000_0213) begin errors++; $display("FAIL bw_instr got=%h exp=a0000213", INSTR_OUT); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_redirect_idle();
    do_reset(1'b1, 4'd0);
    tick(); tick();
    checks++; if (MEM_READ !== 1'b0 || VALID_OUT !== 1'b1 || PC_OUT !== 32'h0) begin errors++; $display("FAIL ri_full got rd=%b v=%b pc=%h exp rd=0 v=1 pc=0", MEM_READ, VALID_OUT, PC_OUT); end
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40; #1;
    tick();
    BRANCH_TAKEN = 1'b0; #1;
    checks++; if (VALID_OUT !== 1'b0 || INSTR_OUT !== NOP) begin errors++; $display("FAIL ri_flush got v=%b i=%h exp v=0 i=%h", VALID_OUT, INSTR_OUT, NOP); end
    checks++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'h10) begin errors++; $display("FAIL ri_addr got rd=%b addr=%h exp rd=1 addr=10", MEM_READ, MEM_ADDRESS); end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'h40 || INSTR_OUT !== 32'hA000_1013) begin errors++; $display("FAIL ri_out got v=%b pc=%h i=%h exp v=1 pc=40 i=a0001013", VALID_OUT, PC_OUT, INSTR_OUT); end
  endtask

  // --------------------------------------------------------------------------
  // Redirect to 0x80 while word 3 is busy; with retarget a second redirect to
  // 0x100 arrives during the drain and must replace the saved target.
  task automatic test_redirect_mid(input logic retarget);
    logic [7:0]  ea;
    logic [31:0] ep, ei;
    ea = retarget ? 8'h40 : 8'h20;
    ep = retarget ? 32'h100 : 32'h80;
    ei = retarget ? 32'hA000_4013 : 32'hA000_2013;
    do_reset(1'b0, 4'd3);
    repeat (12) tick();
    checks++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'd3 || MEM_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL rm_pre got rd=%b addr=%h exp rd=1 addr=03 busy", MEM_READ, MEM_ADDRESS); end
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h80; #1;
    tick();
    BRANCH_TAKEN = 1'b0; #1;
    checks++; if (VALID_OUT !== 1'b0) begin errors++; $display("FAIL rm_flush got v=%b exp=0", VALID_OUT); end
    for (int k = 14; k <= 16; k++) begin
      if (k > 14) tick();
      if (retarget && k == 14) begin
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h100; #1;
        tick();
        BRANCH_TAKEN = 1'b0; #1;
        k++;
      end
      checks++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'd3 || VALID_OUT !== 1'b0) begin errors++; $display("FAIL rm_drain cyc=%0d got rd=%b addr=%h v=%b exp rd=1 addr=03 v=0", k, MEM_READ, MEM_ADDRESS, VALID_OUT); end
    end
    for (int k = 17; k <= 20; k++) begin
      tick();
      checks++; if (VALID_OUT !== 1'b0 || MEM_ADDRESS !== ea) begin errors++; $display("FAIL rm_refetch cyc=%0d got v=%b addr=%h exp v=0 addr=%h", k, VALID_OUT, MEM_ADDRESS, ea); end
    end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== ep || INSTR_OUT !== ei) begin errors++; $display("FAIL rm_out got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", VALID_OUT, PC_OUT, INSTR_OUT, ep, ei); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap();
    do_reset(1'b0, 4'd0);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'hFFFF_FFFC; #1;
    tick();
    BRANCH_TAKEN = 1'b0; #1;
    checks++; if (VALID_OUT !== 1'b0 || MEM_ADDRESS !== 8'hFF) begin errors++; $display("FAIL wrap_req got v=%b addr=%h exp v=0 addr=ff", VALID_OUT, MEM_ADDRESS); end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'hFFFF_FFFC || INSTR_OUT !== 32'hA000_FF13) begin errors++; $display("FAIL wrap_top got v=%b pc=%h i=%h exp v=1 pc=fffffffc i=a000ff13", VALID_OUT, PC_OUT, INSTR_OUT); end
    checks++; if (MEM_ADDRESS !== 8'h00) begin errors++; $display("FAIL wrap_addr got=%h exp=00", MEM_ADDRESS); end
    tick();
    checks++; if (VALID_OUT !== 1'b1 || PC_OUT !== 32'h0 || INSTR_OUT !== 32'h0010_0093) begin errors++; $display("FAIL wrap_zero got v=%b pc=%h i=%h exp v=1 pc=0 i=00100093", VALID_OUT, PC_OUT, INSTR_OUT); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_misaligned();
    do_reset(1'b0, 4'd0);
    BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h42; #1;
    tick();
    BRANCH_TAKEN = 1'b0; #1;
    checks++; if (FAULT !== 1'b1 || MEM_READ !== 1'b0) begin errors++; $display("FAIL mis_fault got f=%b rd=%b exp f=1 rd=0", FAULT, MEM_READ); end
    checks++; if (VALID_OUT !== 1'b0 || INSTR_OUT !== NOP || PC_OUT !== 32'd0) begin errors++; $display("FAIL mis_out got v=%b i=%h pc=%h exp v=0 i=%h pc=0", VALID_OUT, INSTR_OUT, PC_OUT, NOP); end
    repeat (3) tick();
    checks++; if (FAULT !== 1'b1 || MEM_READ !== 1'b0 || VALID_OUT !== 1'b0) begin errors++; $display("FAIL mis_sticky got f=%b rd=%b v=%b exp f=1 rd=0 v=0", FAULT, MEM_READ, VALID_OUT); end
    RESET = 1'b0; #1;
    tick();
    checks++; if (FAULT !== 1'b0 || MEM_READ !== 1'b0) begin errors++; $display("FAIL mis_reset got f=%b rd=%b exp f=0 rd=0", FAULT, MEM_READ); end
    RESET = 1'b1; #1;
    checks++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 8'd0) begin errors++; $display("FAIL mis_restart got rd=%b addr=%h exp rd=1 addr=00", MEM_READ, MEM_ADDRESS); end
  endtask

  initial begin
    RESET = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'd0;
    test_reset();
    test_stall();
    test_busywait();
    test_redirect_idle();
    test_redirect_mid(1'b0);
    test_redirect_mid(1'b1);
    test_wrap();
    test_misaligned();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch-side initiator of the RV32IM pipeline's instruction-memory interface.
- Owns the program counter and issues word-address read requests to the instruction memory, which may be a multi-cycle busywait memory.
- Buffers returned words with their PCs in a 2-entry queue and presents them to the IF/ID stage under a valid/stall handshake.
- Handles branch/jump redirects, including one arriving while a memory read is in flight.

Parameters:
- RESET_VECTOR, 32'h00000000, PC loaded at reset.
- ADDR_W, 8, width of the word address driven to instruction memory.
- NOP_INSTR, 32'h00000013, value shown on INSTR_OUT when no valid instruction (ADDI x0,x0,0).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-low reset.
- MEM_READ  out  1  read request to instruction memory.
- MEM_ADDRESS  out  ADDR_W  word address = fetch_pc[ADDR_W+1:2].
- MEM_READDATA  in  32  instruction word from memory.
- MEM_BUSYWAIT  in  1  memory busy; a read completes in a cycle where MEM_READ=1 and MEM_BUSYWAIT=0.
- STALL  in  1  IF/ID not accepting; head entry held.
- BRANCH_TAKEN  in  1  redirect request from EX.
- BRANCH_TARGET  in  32  redirect PC.
- INSTR_OUT  out  32  head instruction (NOP_INSTR when invalid).
- PC_OUT  out  32  PC of head instruction (0 when invalid).
- VALID_OUT  out  1  head entry valid.
- FAULT  out  1  sticky misaligned-target flag.

Behaviour:

Reset (RESET=0 at a rising edge):
- fetch_pc=RESET_VECTOR, queue count=0, state=FETCH.
- MEM_READ=0, VALID_OUT=0, INSTR_OUT=NOP_INSTR, PC_OUT=0, FAULT=0.
- Reset overrides all other inputs, including during an in-flight read; the late memory response is ignored.

States:
- FETCH:
  - MEM_READ=1 whenever count<2, or count=2 with a pop this cycle.
  - On completion: push {MEM_READDATA, fetch_pc} and set fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC -> 0).
  - If the queue becomes full with no pop, go to HOLD.
- HOLD:
  - MEM_READ=0.
  - On a pop, return to FETCH the next cycle.
- DRAIN:
  - Entered when a redirect arrives while a read is in flight (MEM_READ=1 and MEM_BUSYWAIT=1).
  - Keeps MEM_READ=1 with MEM_ADDRESS unchanged until MEM_BUSYWAIT=0.
  - Discards that data and goes to FETCH at the stored target.
- FAULTED:
  - MEM_READ=0, VALID_OUT=0, FAULT=1. Exits only by reset.

Queue and outputs:
- 2 entries, registered. INSTR_OUT/PC_OUT/VALID_OUT reflect the head after the edge.
- Fetch latency: a word completed in cycle N appears on the outputs in cycle N+1.
- Pop when VALID_OUT=1 and STALL=0.
- Simultaneous push and pop at count=2 is allowed; count stays 2.
- Push to an empty queue with a pop in the same cycle is impossible, since VALID_OUT=0.

Redirect (BRANCH_TAKEN=1):
- Highest priority over push, pop and STALL.
- Next cycle: queue flushed, VALID_OUT=0, and the pending push in that cycle is dropped.
- If no read is in flight: fetch_pc=BRANCH_TARGET, state FETCH.
- If a read is in flight: target saved, state DRAIN.
- A second redirect during DRAIN overwrites the saved target.
- BRANCH_TARGET[1:0]!=0: state FAULTED; the target is not fetched.

MEM_ADDRESS:
- Driven from fetch_pc in every state.
- Stable while MEM_READ=1 and MEM_BUSYWAIT=1.

Test Plan:
- Reset sequence: hold RESET=0 for 2 cycles, release; memory with zero wait returning 0x00100093 at word 0 and 0x00208113 at word 1 -> MEM_ADDRESS 0,1,2...; VALID_OUT rises one cycle after the first completion with PC_OUT=0, INSTR_OUT=0x00100093, then PC_OUT=4, INSTR_OUT=0x00208113.
- Stall backpressure: STALL=1 for 5 cycles, zero-wait memory -> exactly 2 completions, then MEM_READ=0 (HOLD); head stays PC 0. On STALL=0, outputs PC 0,4,8,12 in consecutive cycles with no gap or duplicate.
- Busywait memory: MEM_BUSYWAIT high for 3 cycles per read -> MEM_ADDRESS constant during busy; one instruction every 4 cycles; PCs 0,4,8 in order.
- Redirect idle: BRANCH_TAKEN=1, BRANCH_TARGET=0x40 with queue full -> next cycle VALID_OUT=0, MEM_ADDRESS=0x10; first valid output PC_OUT=0x40.
- Redirect mid-read: redirect to 0x80 while a read of word 3 is busy -> MEM_READ held on address 3 until busywait drops; word-3 data never appears; next request address 0x20; first valid PC_OUT=0x80.
- Misaligned target: BRANCH_TARGET=0x42 -> FAULT=1, MEM_READ=0, VALID_OUT=0, held until RESET=0 clears FAULT to 0.
